sw_lookup_engine: RTL and testbench

// - Unit-propagation switch engine for the SAT accelerator lookup stage.
// - Takes the current unit literal from an internal out-queue (UCQ_out, fed by the UC arbiter).
// - Simplifies each clause streamed in by the clause arbiter, then stores survivors in the clause queue (CLQ).
// - Pushes newly discovered unit literals into an internal in-queue (UCQ_in), drained by the UC arbiter.

---
 rtl/sw_lookup_engine.sv | 199 +++++++++++++++++++
 tb/tb_sw_lookup_engine.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_lookup_engine.sv
// Unit-propagation switch engine: simplifies streamed clauses against the current unit literal.
// Define SW_CONFLICT_DETECT_EN to add the sticky 'conflict' output.

// Show-ahead unit-literal FIFO with wrap-bit pointers.
module sw_ucq #(
  parameter int unsigned LIT_W = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [LIT_W-1:0] din,
  input  logic             pop,
  output logic [LIT_W-1:0] head_c,
  output logic             full_c,
  output logic             empty_c
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      head_r, tail_r;
  logic [LIT_W-1:0] entry_r [DEPTH];
  logic             push_ok, pop_ok;

  assign empty_c = (head_r == tail_r);
  assign full_c  = (head_r[AW-1:0] == tail_r[AW-1:0]) && (head_r[AW] != tail_r[AW]);
  assign pop_ok  = pop && !empty_c;
  // A pop frees the slot the push lands in, so a full FIFO still accepts push+pop.
  assign push_ok = push && (!full_c || pop_ok);
  assign head_c  = entry_r[head_r[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst_n) begin
      head_r <= '0;
      tail_r <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) entry_r[i] <= '0;
    end else begin
      if (push_ok) begin
        entry_r[tail_r[AW-1:0]] <= din;
        tail_r <= tail_r + (AW+1)'(1);
      end
      if (pop_ok) head_r <= head_r + (AW+1)'(1);
    end
  end
endmodule

// Clause queue; write side only, contents are consumed outside this block.
module sw_clq #(
  parameter int unsigned LIT_W      = 11,
  parameter int unsigned CLA_LENGTH = 3,
  parameter int unsigned DEPTH      = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [LIT_W*CLA_LENGTH-1:0] din
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      head, tail;
  logic [LIT_W-1:0] buffer [DEPTH][CLA_LENGTH];
  logic             full_c;

  assign full_c = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      head <= '0;
      tail <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        for (int unsigned j = 0; j < CLA_LENGTH; j++) buffer[i][j] <= '0;
    end else if (push && !full_c) begin
      for (int unsigned j = 0; j < CLA_LENGTH; j++)
        buffer[tail[AW-1:0]][j] <= din[j*LIT_W +: LIT_W];
      tail <= tail + (AW+1)'(1);
    end
  end
endmodule

module sw_lookup_engine #(
  parameter int unsigned LIT_W      = 11,
  parameter int unsigned CLA_LENGTH = 3,
  parameter int unsigned UCQ_SIZE   = 8,
  parameter int unsigned CLQ_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ucarb2UCQ_in_pop,
  output logic [LIT_W-1:0]            UCQ_in2uarb_uc,
  output logic                        UCQ_in_empty,
  input  logic [LIT_W-1:0]            ucarb2UCQ_out_uc,
  input  logic                        ucarb2UCQ_out_push,
  output logic                        UCQ_out_full,
  input  logic [LIT_W*CLA_LENGTH-1:0] carb2sw_cla,
  input  logic                        carb2sw_valid
`ifdef SW_CONFLICT_DETECT_EN
  ,
  output logic                        conflict
`endif
);
  localparam int unsigned CLA_W = LIT_W * CLA_LENGTH;
  localparam int unsigned CNT_W = $clog2(CLA_LENGTH + 1);

  logic             stg_v;
  logic [CLA_W-1:0] stg_cla;
  logic [LIT_W-1:0] cur_lit;

  logic             ucq_out_empty, ucq_in_full;
  logic [LIT_W-1:0] ucq_out_head;
  logic             is_hdr_c, is_cla_c, sat_c, hdr_pop_c;
  logic             clq_push_c, ucq_in_push_c, conflict_c;
  logic [CLA_W-1:0] res_c, clq_din_c;
  logic [CNT_W-1:0] n_c;
  logic [LIT_W-1:0] unit_c, neg_u_c;

  // Stage 0: capture the arbiter beat.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      stg_v   <= 1'b0;
      stg_cla <= '0;
    end else begin
      stg_v   <= carb2sw_valid;
      stg_cla <= carb2sw_cla;
    end
  end

  assign is_hdr_c = stg_v && (stg_cla == '0);
  assign is_cla_c = stg_v && (stg_cla != '0);
  assign neg_u_c  = LIT_W'(~cur_lit + LIT_W'(1));

  // Stage 1: satisfaction test, falsified-literal removal and survivor count.
  always_comb begin
    sat_c  = 1'b0;
    res_c  = stg_cla;
    n_c    = '0;
    unit_c = '0;
    for (int unsigned i = 0; i < CLA_LENGTH; i++) begin
      if (cur_lit != '0 && stg_cla[i*LIT_W +: LIT_W] == cur_lit) sat_c = 1'b1;
      if (cur_lit != '0 && stg_cla[i*LIT_W +: LIT_W] == neg_u_c) res_c[i*LIT_W +: LIT_W] = '0;
    end
    for (int unsigned i = 0; i < CLA_LENGTH; i++) begin
      if (res_c[i*LIT_W +: LIT_W] != '0) begin
        n_c    = n_c + CNT_W'(1);
        unit_c = res_c[i*LIT_W +: LIT_W];
      end
    end
  end

  assign hdr_pop_c     = is_hdr_c && !ucq_out_empty;
  assign clq_push_c    = is_hdr_c || (is_cla_c && !sat_c && n_c != '0);
  assign clq_din_c     = is_hdr_c ? stg_cla : res_c;
  assign ucq_in_push_c = is_cla_c && !sat_c && (n_c == CNT_W'(1)) &&
                         (!ucq_in_full || (ucarb2UCQ_in_pop && !UCQ_in_empty));
  assign conflict_c    = is_cla_c && !sat_c && (n_c == '0);

  // Current unit literal is refreshed only by a header.
  always_ff @(posedge clk) begin
    if (rst_n)         cur_lit <= '0;
    else if (is_hdr_c) cur_lit <= ucq_out_empty ? '0 : ucq_out_head;
  end

`ifdef SW_CONFLICT_DETECT_EN
  always_ff @(posedge clk) begin
    if (rst_n)           conflict <= 1'b0;
    else if (conflict_c) conflict <= 1'b1;
  end
`else
  logic unused_conflict_c;
  assign unused_conflict_c = conflict_c;
`endif

  sw_ucq #(.LIT_W(LIT_W), .DEPTH(UCQ_SIZE)) u_ucq_out (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (ucarb2UCQ_out_push),
    .din    (ucarb2UCQ_out_uc),
    .pop    (hdr_pop_c),
    .head_c (ucq_out_head),
    .full_c (UCQ_out_full),
    .empty_c(ucq_out_empty)
  );

  sw_ucq #(.LIT_W(LIT_W), .DEPTH(UCQ_SIZE)) u_ucq_in (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (ucq_in_push_c),
    .din    (unit_c),
    .pop    (ucarb2UCQ_in_pop),
    .head_c (UCQ_in2uarb_uc),
    .full_c (ucq_in_full),
    .empty_c(UCQ_in_empty)
  );

  sw_clq #(.LIT_W(LIT_W), .CLA_LENGTH(CLA_LENGTH), .DEPTH(CLQ_DEPTH)) u_clq (
    .clk  (clk),
    .rst_n(rst_n),
    .push (clq_push_c),
    .din  (clq_din_c)
  );
endmodule

// File: tb/tb_sw_lookup_engine.sv
// Bench for sw_lookup_engine: directed scenarios plus randomized traffic against a queue-based model.
// Build with SW_CONFLICT_DETECT_EN defined to also check the conflict output.
module tb_sw_lookup_engine;
  localparam int unsigned LIT_W      = 11;
  localparam int unsigned CLA_LENGTH = 3;
  localparam int unsigned UCQ_SIZE   = 8;
  localparam int unsigned CLQ_DEPTH  = 16;
  localparam int unsigned CW         = LIT_W * CLA_LENGTH;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ucarb2UCQ_in_pop;
  logic [LIT_W-1:0] UCQ_in2uarb_uc;
  logic             UCQ_in_empty;
  logic [LIT_W-1:0] ucarb2UCQ_out_uc;
  logic             ucarb2UCQ_out_push;
  logic             UCQ_out_full;
  logic [CW-1:0]    carb2sw_cla;
  logic             carb2sw_valid;
`ifdef SW_CONFLICT_DETECT_EN
  logic             conflict;
`endif

  sw_lookup_engine dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ucarb2UCQ_in_pop  (ucarb2UCQ_in_pop),
    .UCQ_in2uarb_uc    (UCQ_in2uarb_uc),
    .UCQ_in_empty      (UCQ_in_empty),
    .ucarb2UCQ_out_uc  (ucarb2UCQ_out_uc),
    .ucarb2UCQ_out_push(ucarb2UCQ_out_push),
    .UCQ_out_full      (UCQ_out_full),
    .carb2sw_cla       (carb2sw_cla),
    .carb2sw_valid     (carb2sw_valid)
`ifdef SW_CONFLICT_DETECT_EN
    ,
    .conflict          (conflict)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [LIT_W-1:0] m_out[$];
  logic [LIT_W-1:0] m_in[$];
  logic [CW-1:0]    m_clq[$];
  logic [LIT_W-1:0] m_cur;
  logic             m_stg_v;
  logic [CW-1:0]    m_stg_cla;
  logic             m_conf;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int a2, input int a1, input int a0);
    return {LIT_W'(a2), LIT_W'(a1), LIT_W'(a0)};
  endfunction

  // Effect of one clock edge, given the inputs present before it.
  task automatic model_step(input logic rst, input logic push_out, input logic [LIT_W-1:0] uc,
                            input logic pop_in, input logic v, input logic [CW-1:0] cla);
    logic hdr, cl, sat, pop_o, pop_i, psh_i, wr;
    logic [LIT_W-1:0] lit, negu, uni;
    logic [CW-1:0] res;
    int n, osz, isz;
    if (rst) begin
      m_out.delete(); m_in.delete(); m_clq.delete();
      m_cur = '0; m_stg_v = 1'b0; m_stg_cla = '0; m_conf = 1'b0;
      return;
    end
    hdr = m_stg_v && (m_stg_cla == '0);
    cl  = m_stg_v && !hdr;
    osz = m_out.size();
    isz = m_in.size();
    pop_o = hdr && (osz > 0);
    sat = 1'b0; n = 0; uni = '0; res = m_stg_cla; wr = hdr; psh_i = 1'b0;
    negu = LIT_W'(0) - m_cur;
    if (cl) begin
      for (int j = 0; j < CLA_LENGTH; j++) begin
        lit = m_stg_cla[j*LIT_W +: LIT_W];
        if (m_cur != '0 && lit == m_cur) sat = 1'b1;
        if (m_cur != '0 && lit == negu) lit = '0;
        res[j*LIT_W +: LIT_W] = lit;
        if (lit != '0) begin n++; uni = lit; end
      end
      wr    = !sat && (n >= 1);
      psh_i = !sat && (n == 1);
      if (!sat && n == 0) m_conf = 1'b1;
    end
    if (hdr) m_cur = pop_o ? m_out[0] : '0;
    if (wr && m_clq.size() < CLQ_DEPTH) m_clq.push_back(res);
    if (pop_o) void'(m_out.pop_front());
    if (push_out && (osz < UCQ_SIZE || pop_o)) m_out.push_back(uc);
    pop_i = pop_in && (isz > 0);
    if (pop_i) void'(m_in.pop_front());
    if (psh_i && (isz < UCQ_SIZE || pop_i)) m_in.push_back(uni);
    m_stg_v = v;
    m_stg_cla = cla;
  endtask

  task automatic check_all(input string tag);
    check({tag, ":in_empty"}, 64'(UCQ_in_empty), 64'(m_in.size() == 0));
    if (m_in.size() > 0) check({tag, ":in_head"}, 64'(UCQ_in2uarb_uc), 64'(m_in[0]));
    check({tag, ":out_full"}, 64'(UCQ_out_full), 64'(m_out.size() == UCQ_SIZE));
    check({tag, ":cur_lit"}, 64'(dut.cur_lit), 64'(m_cur));
    check({tag, ":clq_count"}, 64'(dut.u_clq.tail), 64'(m_clq.size()));
`ifdef SW_CONFLICT_DETECT_EN
    check({tag, ":conflict"}, 64'(conflict), 64'(m_conf));
`endif
  endtask

  task automatic check_clq(input string tag);
    logic [CW-1:0] e;
    for (int k = 0; k < m_clq.size(); k++) begin
      e = m_clq[k];
      for (int j = 0; j < CLA_LENGTH; j++)
        check($sformatf("%s:clq[%0d][%0d]", tag, k, j), 64'(dut.u_clq.buffer[k][j]),
              64'(e[j*LIT_W +: LIT_W]));
    end
  endtask

  task automatic cyc(input string tag, input logic rst, input logic push_out,
                     input logic [LIT_W-1:0] uc, input logic pop_in,
                     input logic v, input logic [CW-1:0] cla);
    rst_n              = rst;
    ucarb2UCQ_out_push = push_out;
    ucarb2UCQ_out_uc   = uc;
    ucarb2UCQ_in_pop   = pop_in;
    carb2sw_valid      = v;
    carb2sw_cla        = cla;
    model_step(rst, push_out, uc, pop_in, v, cla);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    cyc(tag, 1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    check({tag, ":rst_in_empty"}, 64'(UCQ_in_empty), 64'(1));
    check({tag, ":rst_out_full"}, 64'(UCQ_out_full), 64'(0));
    check({tag, ":rst_in_uc"}, 64'(UCQ_in2uarb_uc), 64'(0));
  endtask

  logic [CW-1:0] spec_clq [4];

  initial begin
    rst_n = 1'b1; ucarb2UCQ_in_pop = 1'b0; ucarb2UCQ_out_push = 1'b0;
    ucarb2UCQ_out_uc = '0; carb2sw_valid = 1'b0; carb2sw_cla = '0;

    // Reset-release sequence with unit literal -1
    do_reset("init");
    do_reset("init2");
    cyc("s1_hdr", 1'b0, 1'b1, '1, 1'b0, 1'b1, '0);
    cyc("s1_c1",  1'b0, 1'b0, '0, 1'b0, 1'b1, mk(1, 2, 7));
    cyc("s1_c2",  1'b0, 1'b0, '0, 1'b0, 1'b1, mk(2, -1, 5));
    cyc("s1_c3",  1'b0, 1'b0, '0, 1'b0, 1'b1, mk(0, 3, 1));
    cyc("s1_c4",  1'b0, 1'b0, '0, 1'b0, 1'b1, mk(6, 3, 1));
    cyc("s1_end", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    spec_clq[0] = mk(0, 0, 0); spec_clq[1] = mk(0, 2, 7);
    spec_clq[2] = mk(0, 3, 0); spec_clq[3] = mk(6, 3, 0);
    check("s1_clq_n", 64'(dut.u_clq.tail), 64'(4));
    for (int k = 0; k < 4; k++)
      check($sformatf("s1_clq_entry%0d", k),
            64'({dut.u_clq.buffer[k][2], dut.u_clq.buffer[k][1], dut.u_clq.buffer[k][0]}),
            64'(spec_clq[k]));
    check("s1_in_empty", 64'(UCQ_in_empty), 64'(0));
    check("s1_in_head", 64'(UCQ_in2uarb_uc), 64'(3));
    cyc("s1_pop", 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    check("s1_in_single", 64'(UCQ_in_empty), 64'(1));

    // Header with empty UCQ_out, then unit clause under cur_lit=0
    do_reset("s2_rst");
    cyc("s2_hdr", 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    cyc("s2_c",   1'b0, 1'b0, '0, 1'b0, 1'b1, mk(4, 5, 6));
    cyc("s2_hdr2", 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    check("s2_in_none", 64'(UCQ_in_empty), 64'(1));
    cyc("s3_c",   1'b0, 1'b0, '0, 1'b0, 1'b1, mk(0, 0, 9));
    cyc("s3_idle", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("s3_in_head", 64'(UCQ_in2uarb_uc), 64'(9));
    cyc("s3_pop", 1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    check("s3_in_empty", 64'(UCQ_in_empty), 64'(1));
    check_clq("s3");

    // Conflict: cur_lit=2 against clause (0,0,-2)
    do_reset("s4_rst");
    cyc("s4_hdr", 1'b0, 1'b1, LIT_W'(2), 1'b0, 1'b1, '0);
    cyc("s4_c",   1'b0, 1'b0, '0, 1'b0, 1'b1, mk(0, 0, -2));
    cyc("s4_idle", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("s4_cur", 64'(dut.cur_lit), 64'(2));
    check("s4_clq_hdr_only", 64'(dut.u_clq.tail), 64'(1));
    for (int i = 0; i < 3; i++) cyc("s4_sticky", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
`ifdef SW_CONFLICT_DETECT_EN
    check("s4_conflict", 64'(conflict), 64'(1));
`endif

    // UCQ_out fill past capacity, then push+pop while full
    do_reset("s5_rst");
    for (int i = 1; i <= UCQ_SIZE + 1; i++)
      cyc($sformatf("s5_push%0d", i), 1'b0, 1'b1, LIT_W'(i), 1'b0, 1'b0, '0);
    check("s5_full", 64'(UCQ_out_full), 64'(1));
    cyc("s5_hdr", 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    cyc("s5_pushpop", 1'b0, 1'b1, LIT_W'(20), 1'b0, 1'b0, '0);
    check("s5_full_kept", 64'(UCQ_out_full), 64'(1));
    check("s5_cur", 64'(dut.cur_lit), 64'(1));

    // Reset mid-stream
    cyc("s6_hdr", 1'b0, 1'b0, '0, 1'b0, 1'b1, '0);
    cyc("s6_c",   1'b0, 1'b0, '0, 1'b0, 1'b1, mk(0, 0, 7));
    do_reset("s6_rst");
    cyc("s6_after", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    check("s6_clq_empty", 64'(dut.u_clq.tail), 64'(0));

    // Randomized traffic on a small literal alphabet
    for (int r = 0; r < 30; r++) begin
      do_reset("rnd_rst");
      for (int c = 0; c < 13; c++) begin
        logic hdr_sel, v;
        logic [CW-1:0] cla;
        v = ($urandom_range(0, 3) != 0);
        hdr_sel = ($urandom_range(0, 9) < 3);
        cla = hdr_sel ? '0 : mk($urandom_range(0, 6) - 3, $urandom_range(0, 6) - 3,
                                $urandom_range(0, 6) - 3);
        cyc("rnd", 1'b0, ($urandom_range(0, 9) < 4), LIT_W'($urandom_range(0, 6) - 3),
            ($urandom_range(0, 9) < 3), v, cla);
      end
      cyc("rnd_flush", 1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
      check_clq("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
